// File: rtl/lcd_snapshot_tx.sv
// lcd_snapshot_tx
//   Captures one coherent snapshot of the CPU LCD taps when triggered. It then
//   streams the snapshot as a fixed-length byte frame over a valid/ready link:
//     HEADER, PC bytes, instruction bytes, r0..r(NREGS-1) bytes, checksum
//   Multi-byte fields are sent MSB byte first. The checksum is the 8-bit sum
//   of the payload bytes only; the header is not included.
// Ports:
//   clk_2           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   trigger         capture request; only accepted while idle
//   lcd_pc          program counter tap
//   lcd_instruction current instruction tap
//   lcd_registrador register file tap [0:NREGS-1]
//   tx_data         current frame byte (0 when idle)
//   tx_valid        tx_data holds a byte to transfer
//   tx_ready        sink accepts the byte
//   busy            frame in progress
//   overrun         sticky flag: a trigger arrived while busy
module lcd_snapshot_tx #(
  parameter int unsigned NBITS       = 8,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned NINSTR_BITS = 32,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                   clk_2,
  input  logic                   reset_n,
  input  logic                   trigger,
  input  logic [NBITS-1:0]       lcd_pc,
  input  logic [NINSTR_BITS-1:0] lcd_instruction,
  input  logic [NBITS-1:0]       lcd_registrador [0:NREGS-1],
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned PCB  = NBITS / 8;
  localparam int unsigned IB   = NINSTR_BITS / 8;
  localparam int unsigned RB   = NBITS / 8;
  localparam int unsigned P    = PCB + IB + NREGS * RB;
  localparam int unsigned L    = P + 2;
  localparam int unsigned IDXW = $clog2(L);
  localparam logic [IDXW-1:0] LAST = IDXW'(P - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECKSUM
  } state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q;
  logic [7:0]             csum_q;
  logic [NBITS-1:0]       pc_sh;
  logic [NINSTR_BITS-1:0] instr_sh;
  logic [NBITS-1:0]       regs_sh [0:NREGS-1];
  logic [7:0]             pbytes  [0:P-1];
  logic [7:0]             cur_byte;
  logic                   capture;

  // Flattened view of the payload as a byte array, in transmit order.
  always_comb begin
    for (int unsigned b = 0; b < PCB; b++)
      pbytes[b] = pc_sh[NBITS-1-8*b -: 8];
    for (int unsigned b = 0; b < IB; b++)
      pbytes[PCB+b] = instr_sh[NINSTR_BITS-1-8*b -: 8];
    for (int unsigned r = 0; r < NREGS; r++)
      for (int unsigned b = 0; b < RB; b++)
        pbytes[PCB+IB+r*RB+b] = regs_sh[r][NBITS-1-8*b -: 8];
  end

  assign cur_byte = pbytes[idx_q];
  assign capture  = (state_q == S_IDLE) && trigger;

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_HEADER;
      end
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready && (idx_q == LAST)) state_d = S_CHECKSUM;
      end
      S_CHECKSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      csum_q   <= '0;
      overrun  <= 1'b0;
      pc_sh    <= '0;
      instr_sh <= '0;
      for (int unsigned r = 0; r < NREGS; r++) regs_sh[r] <= '0;
    end else begin
      state_q <= state_d;
      if (trigger && (state_q != S_IDLE)) overrun <= 1'b1;
      if (capture) begin
        pc_sh    <= lcd_pc;
        instr_sh <= lcd_instruction;
        for (int unsigned r = 0; r < NREGS; r++) regs_sh[r] <= lcd_registrador[r];
        csum_q   <= '0;
        idx_q    <= '0;
      end
      if ((state_q == S_PAYLOAD) && tx_ready) begin
        csum_q <= csum_q + cur_byte;
        // Index parks on the last payload byte rather than wrapping.
        if (idx_q != LAST) idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule
